ij_debouncer: RTL

IJ_DEBOUNCER -- requirements
Module: ij_debouncer

---
 rtl/ij_debouncer.sv | 111 +++++++++++
 1 files changed

// File: rtl/ij_debouncer.sv
// Two-channel switch debouncer: each raw input is synchronized, then must hold a
// new level for STABLE_CYCLES consecutive cycles before the registered output follows.

module ij_debouncer_chan #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam int unsigned    CW   = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0]  TERM = CW'(STABLE_CYCLES - 1);

  typedef enum logic {STABLE, CONFIRM} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          s1, s2;
  logic          out_nx, rise_nx, fall_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= STABLE;
      cnt   <= '0;
      out   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      state <= state_nx;
      cnt   <= cnt_nx;
      out   <= out_nx;
      rise  <= rise_nx;
      fall  <= fall_nx;
    end
  end

  // Entering CONFIRM already counts the first mismatching cycle, so the flip
  // happens on the STABLE_CYCLES-th consecutive mismatch.
  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    out_nx   = out;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    case (state)
      STABLE: begin
        if (s2 != out) begin
          state_nx = CONFIRM;
          cnt_nx   = CW'(1);
        end
      end
      CONFIRM: begin
        if (s2 == out) begin
          state_nx = STABLE;
        end else if (cnt == TERM) begin
          state_nx = STABLE;
          out_nx   = s2;
          rise_nx  = s2;
          fall_nx  = ~s2;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = STABLE;
    endcase
  end

endmodule

module ij_debouncer #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  input  logic j_raw,
  output logic i,
  output logic j,
  output logic i_rise,
  output logic i_fall,
  output logic j_rise,
  output logic j_fall
);

  ij_debouncer_chan #(.STABLE_CYCLES(STABLE_CYCLES)) u_chan_i (
    .clk  (clk),
    .rst  (rst),
    .raw  (i_raw),
    .out  (i),
    .rise (i_rise),
    .fall (i_fall)
  );

  ij_debouncer_chan #(.STABLE_CYCLES(STABLE_CYCLES)) u_chan_j (
    .clk  (clk),
    .rst  (rst),
    .raw  (j_raw),
    .out  (j),
    .rise (j_rise),
    .fall (j_fall)
  );

endmodule
